player_sprite_loader: RTL and testbench
=======================================

# player_sprite_loader

Writer side of the player sprite interface. It accepts a byte stream of 300 8-bit pixels over a valid/ready handshake and assembles them into a back buffer. At a fixed VGA line it commits the back buffer to the 2400-bit `player` bus read by the player display blocks, so the sprite never changes mid-frame. The block sits between the sprite source (ROM reader or host link) and the display path.

## Interface
- `NUM_PIX`, 300: pixels per sprite (15 wide x 20 tall).
- `PIX_W`, 8: bits per pixel.
- `COMMIT_LINE`, 11'd600: `Vcnt` value at which a pending sprite is committed.

- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle request to begin a new sprite load; aborts any load in progress.
- `in_valid`  in  1  source has a pixel on `in_data`.
- `in_data`  in  8  pixel colour; 0 means "use default colour" downstream.
- `in_ready`  out  1  loader accepts a pixel this cycle.
- `Hcnt`  in  11  VGA horizontal counter.
- `Vcnt`  in  11  VGA vertical counter.
- `player`  out  2400  front buffer, registered, consumed by the display.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse, high in the first cycle the new `player` value is visible.

## Operation
- States:
  - IDLE: reset state; `in_ready`=0.
  - LOAD: `in_ready`=1.
  - PEND: back buffer full, waiting for commit; `in_ready`=0.
- Pixel index counter `cnt`, 9 bits, range 0..NUM_PIX-1.
- Transfer happens only on a cycle with `in_valid && in_ready`.
- Pixel ordering:
  - Pixel k (row-major, top-left first) is written to `back[(NUM_PIX-1-k)*8 +: 8]`.
  - The first pixel therefore lands in bits [2399:2392] and the last in bits [7:0].
  - This matches the display's decreasing-index addressing.
- Transitions:
  - IDLE --start--> LOAD: `cnt`<=0, back<=0.
  - LOAD, transfer with `cnt`<NUM_PIX-1: write the pixel, `cnt`<=`cnt`+1.
  - LOAD, transfer with `cnt`==NUM_PIX-1: write the pixel, go to PEND, `cnt`<=0.
  - PEND, sampled `Vcnt`==COMMIT_LINE && `Hcnt`==0: `player`<=back, `done`<=1, go to IDLE.
  - `start` in LOAD or PEND returns to LOAD with `cnt`<=0 and back<=0. In PEND the pending sprite is discarded. In LOAD a transfer in the same cycle is ignored.
- Simultaneous events:
  - PEND with commit condition and `start` in the same cycle: the commit occurs and `done` pulses, then the state goes to LOAD with `cnt`=0 and back cleared.
  - Commit condition while in LOAD or IDLE: ignored.
- `player` changes only on a commit (or reset). It holds its value for any length of time otherwise.
- An incomplete load never reaches `player`.
- There is no timeout. LOAD waits indefinitely for pixels.

## Timing
- Reset values:
  - `player`=0; the display shows its default colour everywhere.
  - back=0, `cnt`=0, state IDLE.
  - `in_ready`=0, `busy`=0, `done`=0.
- `in_ready` and `busy` are decoded from the registered state only, with no combinational path from inputs.
  - `in_ready` rises the cycle after `start`.
  - `in_ready` falls the cycle after the 300th transfer.
- Minimum load takes 300 cycles with `in_valid` held high. PEND is entered on the edge that accepts the last pixel.
- Commit latency:
  - The commit condition is sampled on edge N.
  - `player` takes the new value and `done`=1 in cycle N+1.
  - `done`=0 in cycle N+2.
- At most one commit per frame. `Hcnt`==0 occurs once per line.
- Asynchronous `rst` mid-load or mid-PEND forces all reset values immediately. No partial data survives.

## Test plan
- **Reset:** assert `rst` mid-cycle with `player` nonzero. Required: `player`=0, `in_ready`=0, `busy`=0, `done`=0 without waiting for a clock edge.
- **Full load:** pulse `start`, then stream 300 bytes with byte k = k[7:0] and `in_valid` held high. Required:
  - `in_ready` is high for exactly 300 cycles.
  - After commit, `player[2399:2392]`=0x00, `player[2391:2384]`=0x01, `player[7:0]`=0x2B.
- **Frame sync:** finish a load at `Vcnt`=100. Required:
  - `player` is unchanged through `Vcnt`=599.
  - It updates on the cycle after `Vcnt`=600, `Hcnt`=0, with a single-cycle `done` pulse.
  - `busy`=0 afterwards.
- **Backpressure and gaps:** toggle `in_valid` pseudo-randomly. Required:
  - Only handshaked bytes are stored.
  - The final `player` equals the sent sequence in order.
  - The 301st offered byte is not accepted (`in_ready`=0).
- **Abort:** commit sprite A, then `start` and send 150 bytes of sprite B, then `start` again and send a full sprite C. Required:
  - `player`=A until the commit.
  - `player`=C after it, with no B bytes present.
- **Simultaneous:** `start` in the PEND commit cycle. Required:
  - `player` takes the pending sprite and `done` pulses.
  - The state is LOAD with `cnt`=0 the next cycle.

Source files
------------

// File: rtl/player_sprite_loader.sv
// Player sprite writer: collects a 300-pixel byte stream into a back buffer and
// commits it to the display-facing front buffer at a fixed VGA line.
module player_sprite_loader #(
    parameter int          NUM_PIX     = 300,
    parameter int          PIX_W       = 8,
    parameter logic [10:0] COMMIT_LINE = 11'd600
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [PIX_W-1:0]         in_data,
    output logic                     in_ready,
    input  logic [10:0]              Hcnt,
    input  logic [10:0]              Vcnt,
    output logic [NUM_PIX*PIX_W-1:0] player,
    output logic                     busy,
    output logic                     done
);

    localparam int BUF_W  = NUM_PIX * PIX_W;
    localparam int BASE_W = $clog2(BUF_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [8:0]        cnt;
    logic [BUF_W-1:0]  back;
    logic              clr;
    logic              wr;
    logic              commit;
    logic              cnt_last;
    logic              commit_cond;
    logic [BASE_W-1:0] base;

    assign cnt_last    = (cnt == 9'(NUM_PIX - 1));
    assign commit_cond = (Vcnt == COMMIT_LINE) && (Hcnt == 11'd0);
    // Pixel k lands at the top end of the buffer first (display reads high to low).
    assign base        = BASE_W'((NUM_PIX - 1 - int'(cnt)) * PIX_W);

    assign in_ready = (state == LOAD);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        clr        = 1'b0;
        wr         = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                    clr        = 1'b1;
                end
            end
            LOAD: begin
                if (start) begin
                    clr = 1'b1;
                end else if (in_valid) begin
                    wr = 1'b1;
                    if (cnt_last) begin
                        state_next = PEND;
                    end
                end
            end
            PEND: begin
                // A start in the commit cycle still lets the pending sprite through.
                if (commit_cond) begin
                    commit     = 1'b1;
                    state_next = IDLE;
                end
                if (start) begin
                    state_next = LOAD;
                    clr        = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            back   <= '0;
            player <= '0;
            done   <= 1'b0;
        end else begin
            done <= commit;
            if (commit) begin
                player <= back;
            end
            if (clr) begin
                cnt  <= '0;
                back <= '0;
            end else if (wr) begin
                back[base +: PIX_W] <= in_data;
                cnt                 <= cnt_last ? 9'd0 : cnt + 9'd1;
            end
        end
    end

endmodule

// File: tb/tb_player_sprite_loader.sv
// Scoreboard bench for player_sprite_loader: completed sprites are queued by the
// stimulus side and compared against the front buffer on every done pulse.
module tb_player_sprite_loader;

    localparam int NP = 300;
    localparam int BW = NP * 8;

    logic          clk;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic [10:0]   Hcnt;
    logic [10:0]   Vcnt;
    logic [BW-1:0] player;
    logic          busy;
    logic          done;

    player_sprite_loader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .Hcnt     (Hcnt),
        .Vcnt     (Vcnt),
        .player   (player),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            total = 0;
    int            bad   = 0;
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] model_back;
    int            model_cnt;
    logic [BW-1:0] exp_player;
    int            ready_cycles;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic cmp_sprite(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        logic [2431:0] o;
        logic [2431:0] e;
        o = {32'b0, obs};
        e = {32'b0, exp};
        for (int w = 0; w < 38; w++) begin
            chk($sformatf("%s_w%0d", tag, w), o[w*64 +: 64], e[w*64 +: 64]);
        end
    endtask

    function automatic logic [7:0] pix(input int pat, input int k);
        logic [7:0] v;
        case (pat)
            0:       v = 8'(k);
            1:       v = 8'(k * 5 + 17);
            2:       v = 8'(8'hB0 + (k % 16));
            3:       v = 8'(255 - k);
            4:       v = 8'(k * 13 + 1);
            default: v = 8'($urandom);
        endcase
        return v;
    endfunction

    // Every done pulse must match the oldest completed sprite.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("done_unexpected", 64'(done), 64'(0));
            end else begin
                exp_player = exp_q.pop_front();
                cmp_sprite("commit", player, exp_player);
            end
        end
    end

    task automatic pulse_start();
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        @(posedge clk); #1;
        start      = 1'b0;
        in_valid   = 1'b0;
        model_back = '0;
        model_cnt  = 0;
    endtask

    task automatic send(input int n, input int pat, input bit gaps);
        int         k;
        int         budget;
        logic [7:0] b;
        k            = 0;
        budget       = 0;
        ready_cycles = 0;
        b            = pix(pat, 0);
        while (k < n && budget < 5000) begin
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = in_valid ? b : 8'($urandom);
            @(negedge clk);
            if (in_ready) ready_cycles++;
            if (in_valid && in_ready) begin
                model_back[(NP - 1 - model_cnt) * 8 +: 8] = b;
                model_cnt++;
                k++;
                if (model_cnt == NP) begin
                    exp_q.push_back(model_back);
                    model_cnt = 0;
                end
                b = pix(pat, k);
            end
            budget++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (k < n) chk("send_timeout", 64'(k), 64'(n));
    endtask

    task automatic commit(input bit exp_done);
        Vcnt = 11'd600;
        Hcnt = 11'd0;
        @(posedge clk); #1;
        Vcnt = 11'd0;
        Hcnt = 11'd5;
        @(negedge clk);
        chk("commit_done", 64'(done), 64'(exp_done));
        @(posedge clk); #1;
        @(negedge clk);
        chk("done_fall", 64'(done), 64'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        int changes;
        logic [BW-1:0] prev;
        rst        = 1'b1;
        start      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        Hcnt       = 11'd5;
        Vcnt       = 11'd0;
        model_back = '0;
        model_cnt  = 0;
        exp_player = '0;
        #2;
        chk("rst0_player", 64'(|player), 64'(0));
        chk("rst0_ready", 64'(in_ready), 64'(0));
        chk("rst0_busy", 64'(busy), 64'(0));
        chk("rst0_done", 64'(done), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // full load with byte k = k
        pulse_start();
        send(NP, 0, 1'b0);
        chk("full_ready_cycles", 64'(ready_cycles), 64'(NP));
        @(negedge clk);
        chk("full_ready_after", 64'(in_ready), 64'(0));
        chk("full_busy_pend", 64'(busy), 64'(1));
        @(posedge clk); #1;
        commit(1'b1);
        chk("full_byte0", 64'(player[2399:2392]), 64'(8'h00));
        chk("full_byte1", 64'(player[2391:2384]), 64'(8'h01));
        chk("full_byte299", 64'(player[7:0]), 64'(8'h2B));
        chk("full_busy_after", 64'(busy), 64'(0));

        // frame sync: load completes at line 100, commit only at line 600 / Hcnt 0
        pulse_start();
        Vcnt = 11'd100;
        Hcnt = 11'd3;
        send(NP, 1, 1'b0);
        prev    = exp_player;
        changes = 0;
        for (int v = 100; v < 600; v++) begin
            for (int h = 0; h < 2; h++) begin
                Vcnt = 11'(v);
                Hcnt = 11'(h);
                @(negedge clk);
                if (player !== prev || done !== 1'b0) changes++;
                @(posedge clk); #1;
            end
        end
        Vcnt = 11'd600;
        Hcnt = 11'd1;
        @(negedge clk);
        if (player !== prev || done !== 1'b0) changes++;
        chk("sync_hold_changes", 64'(changes), 64'(0));
        @(posedge clk); #1;
        commit(1'b1);
        chk("sync_busy_after", 64'(busy), 64'(0));
        commit(1'b0);
        cmp_sprite("idle_commit_hold", player, exp_player);

        // backpressure with random gaps and random data
        pulse_start();
        send(NP, 9, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h77;
        @(negedge clk);
        chk("bp_301st_ready", 64'(in_ready), 64'(0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        commit(1'b1);

        // abort: partial sprite B never reaches the front buffer
        pulse_start();
        send(150, 2, 1'b0);
        commit(1'b0);
        cmp_sprite("abort_load_hold", player, exp_player);
        pulse_start();
        send(NP, 3, 1'b0);
        cmp_sprite("abort_pend_hold", player, exp_player);
        commit(1'b1);

        // start in the commit cycle of PEND
        pulse_start();
        send(NP, 4, 1'b0);
        Vcnt  = 11'd600;
        Hcnt  = 11'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        Vcnt       = 11'd0;
        Hcnt       = 11'd5;
        model_back = '0;
        model_cnt  = 0;
        @(negedge clk);
        chk("sim_done", 64'(done), 64'(1));
        chk("sim_ready_load", 64'(in_ready), 64'(1));
        chk("sim_busy", 64'(busy), 64'(1));
        @(posedge clk); #1;
        send(NP, 0, 1'b1);
        commit(1'b1);

        // asynchronous reset in the middle of a load
        pulse_start();
        send(100, 1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("rst_player", 64'(|player), 64'(0));
        chk("rst_ready", 64'(in_ready), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        exp_q.delete();
        exp_player = '0;
        model_cnt  = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        commit(1'b0);
        cmp_sprite("post_rst_hold", player, exp_player);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
